vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Produces the VGA raster: pixel coordinates x_pos/y_pos, active-low hsync/vsync, and a video_on qualifier.
- Its outputs drive the pixel/sprite renderer, which is the consumer of x_pos/y_pos, and the VGA connector.
- Derives a pixel-rate enable from the system clock, runs the horizontal and vertical counters, and issues line-start and frame-start strobes. The renderer uses frame_start for once-per-frame ball motion updates.

Parameters:
- CLK_DIV, 2, system clocks per pixel (1..16); 50 MHz / 2 = 25 MHz pixel rate.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- Derived (not overridable): H_TOTAL = 800, V_TOTAL = 525 at the defaults. Both totals must be ≤ 1024.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset: asserts when low, deasserts synchronously to clk.
- en  in  1  run enable; when low, all state and outputs freeze.
- x_pos  out  10  horizontal count, 0..H_TOTAL-1.
- y_pos  out  10  vertical count, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- video_on  out  1  high when x_pos < H_ACTIVE and y_pos < V_ACTIVE.
- pixel_tick  out  1  one-clk strobe, once per pixel period.
- line_start  out  1  one-clk strobe when x_pos wraps to 0.
- frame_start  out  1  one-clk strobe when (x_pos, y_pos) wraps to (0,0).

Behaviour:
- Reset (reset low, asynchronous):
  - prescaler = 0, x_pos = 0, y_pos = 0.
  - hsync = 1, vsync = 1.
  - video_on = 0, pixel_tick = 0, line_start = 0, frame_start = 0.
- Prescaler:
  - 4-bit counter, counts 0..CLK_DIV-1 while en = 1.
  - pixel_tick is a registered output, high for exactly one clk on the edge where the prescaler wraps to 0.
  - CLK_DIV = 1: pixel_tick is high on every enabled clk.
- Horizontal counter: advances on each clk where the internal tick condition holds (en = 1 and prescaler = CLK_DIV-1). x_pos = H_TOTAL-1 wraps to 0.
- Vertical counter: advances only on a horizontal wrap. y_pos = V_TOTAL-1 wraps to 0 on that same edge.
- Registered decodes:
  - hsync, vsync and video_on are computed from the next counter values.
  - They are registered on the same edge as x_pos/y_pos, so all outputs change together with zero skew and no decode latency.
- Decode windows:
  - hsync = 0 for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751; else 1.
  - vsync = 0 for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491; else 1.
  - video_on = 1 iff x < 640 and y < 480.
- Strobes:
  - line_start is high for the one clk on the edge where x_pos becomes 0.
  - frame_start is high for the one clk where both counters become 0. line_start is also high on that clk.
  - Both are coincident with pixel_tick.
- Post-reset start:
  - The first pixel period after reset shows (0,0) with video_on = 0.
  - No frame_start is issued until the first full wrap.
  - The first frame is therefore one pixel short of visible. This is accepted.
- en low:
  - Prescaler, counters and all level outputs hold.
  - Strobes are forced to 0.
  - When en rises, counting resumes from the held prescaler value.
- Reset mid-frame: returns everything to reset values immediately, regardless of the clock.
- Periods at defaults with CLK_DIV = 2:
  - Line = 1600 clks.
  - Frame = 840000 clks.
  - frame_start period = 840000 clks.

Test Plan:
- Reset released, en = 1, CLK_DIV = 2 -> pixel_tick on every 2nd clk; x_pos steps 0→1 on the first tick; hsync = vsync = 1; video_on = 1 from x = 1.
- Run to x = 655→656 -> hsync falls on the same edge x_pos becomes 656. It rises when x_pos becomes 752. video_on falls when x_pos becomes 640.
- Run to the end of line 0 (x = 799) -> next tick gives x = 0, y = 1, line_start = 1 for one clk, frame_start = 0.
- Run a full frame -> vsync low exactly while y ∈ {490, 491}. At the (799,524)→(0,0) wrap, frame_start = 1 and line_start = 1 for one clk. Successive frame_start pulses are 840000 clks apart.
- Drop en for 37 clks mid-line at x = 300 -> x_pos stays 300, no strobes; on en = 1 the count continues from 301 with an unchanged tick phase.
- Assert reset at (400, 200) between clk edges -> outputs go to reset values immediately. After release, the sequence restarts identically to the first scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// A prescaler turns the system clock into a pixel-rate tick. The tick drives the
// horizontal and vertical counters. Sync, video_on and the line/frame strobes are
// decoded from the next counter values and registered on the same edge as the
// counters, so every output moves together with no decode latency.
// Both totals are expected to be <= 1024 because the coordinate outputs are 10 bits.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] PRE_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0] presc_q, presc_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       vo_q, vo_d;
  logic       pt_q, pt_d;
  logic       ls_q, ls_d;
  logic       fs_q, fs_d;

  logic       tick;
  logic       h_wrap;
  logic       v_wrap;

  // Next-state: prescaler, counters, and decodes of the next counter values.
  // Decodes only refresh on a tick, so the first pixel period after reset keeps
  // video_on low even though (0,0) is inside the visible area.
  always_comb begin
    presc_d = presc_q;
    x_d     = x_q;
    y_d     = y_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    vo_d    = vo_q;
    pt_d    = 1'b0;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    tick   = en && (presc_q == PRE_LAST);
    h_wrap = (x_q == H_LAST);
    v_wrap = (y_q == V_LAST);

    if (en) begin
      presc_d = tick ? 4'd0 : presc_q + 4'd1;
    end

    if (tick) begin
      x_d = h_wrap ? 10'd0 : x_q + 10'd1;
      if (h_wrap) begin
        y_d = v_wrap ? 10'd0 : y_q + 10'd1;
      end
      hs_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vs_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
      vo_d = (x_d < H_VIS) && (y_d < V_VIS);
      pt_d = 1'b1;
      ls_d = h_wrap;
      fs_d = h_wrap && v_wrap;
    end
  end

  // State register; sync outputs idle high in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= 4'd0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      vo_q    <= 1'b0;
      pt_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vo_q    <= vo_d;
      pt_q    <= pt_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vo_q;
  assign pixel_tick  = pt_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
